// File: rtl/cache_pkg.sv
// Shared definitions for the L1 miss path: miss FSM states and line geometry.
package cache_pkg;

  localparam int unsigned LINE_BEATS = 4;
  localparam int unsigned BEAT_W     = $clog2(LINE_BEATS);
  localparam int unsigned WAY_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_WB_DATA,
    ST_FILL_REQ,
    ST_FILL_DATA,
    ST_COMMIT
  } miss_state_e;

endpackage

// File: rtl/miss_ctrl_if.sv
// Memory-side command / writeback / fill bus of the L1 miss handler.
interface miss_ctrl_if #(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wvalid;
  logic              mem_wready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wvalid,
    input  mem_gnt, mem_wready, mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wvalid,
    output mem_gnt, mem_wready, mem_rdata, mem_rvalid
  );

endinterface

// File: rtl/line_beat_ctr.sv
// Beat counter shared by the writeback and fill transfers of one cache line.
module line_beat_ctr #(
  parameter int unsigned BEATS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     inc_i,
  output logic [$clog2(BEATS)-1:0] cnt_o,
  output logic                     last_o
);

  localparam int unsigned CW = $clog2(BEATS);

  logic [CW-1:0] cnt_q;

  // BEATS is a power of two, so the natural wrap lands on 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CW'(BEATS - 1));

endmodule

// File: rtl/miss_ctrl.sv
// L1 miss handler: optional dirty-victim writeback, line fill, then tag/valid commit.
module miss_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned TAG_W  = 14,
  parameter int unsigned IDX_W  = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BEATS  = LINE_BEATS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pe_access_d,
  input  logic [TAG_W-1:0]         pe_tag_d,
  input  logic [IDX_W-1:0]         pe_index_d,
  input  logic                     way_is_selected_d,
  input  logic                     req_clean_d,
  input  logic [WAY_W-1:0]         fill_or_victim_way_d,
  input  logic [TAG_W-1:0]         victim_tag_d,
  output logic                     pe_stall,
  miss_ctrl_if.master              mem_bus,
  output logic [WAY_W-1:0]         arr_way,
  output logic [IDX_W-1:0]         arr_index,
  output logic [$clog2(BEATS)-1:0] arr_beat,
  input  logic [DATA_W-1:0]        arr_rdata,
  output logic                     arr_we,
  output logic [DATA_W-1:0]        arr_wdata,
  output logic                     tag_we,
  output logic [TAG_W-1:0]         tag_wdata,
  output logic                     val_set,
  output logic                     val_clr,
  output logic                     mod_clr,
  output logic                     fill_done
);

  localparam int unsigned BW = $clog2(BEATS);

  miss_state_e      state_q;
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] vtag_q;
  logic [IDX_W-1:0] idx_q;
  logic [WAY_W-1:0] way_q;
  logic             val_clr_q;

  logic          miss_c;
  logic          busy_c;
  logic          in_wb_data_c;
  logic          in_fill_data_c;
  logic          ctr_clr_c;
  logic          ctr_inc_c;
  logic [BW-1:0] beat_cnt;
  logic          beat_last;

  assign busy_c         = (state_q != ST_IDLE);
  assign miss_c         = !busy_c && pe_access_d && !way_is_selected_d;
  assign in_wb_data_c   = (state_q == ST_WB_DATA);
  assign in_fill_data_c = (state_q == ST_FILL_DATA);
  assign ctr_clr_c      = ((state_q == ST_WB_REQ) || (state_q == ST_FILL_REQ)) && mem_bus.mem_gnt;
  assign ctr_inc_c      = (in_wb_data_c && mem_bus.mem_wready) ||
                          (in_fill_data_c && mem_bus.mem_rvalid);

  line_beat_ctr #(.BEATS(BEATS)) u_beat_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (ctr_clr_c),
    .inc_i  (ctr_inc_c),
    .cnt_o  (beat_cnt),
    .last_o (beat_last)
  );

  // Miss sequencer; val_clr_q marks the first FILL_REQ cycle only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tag_q     <= '0;
      vtag_q    <= '0;
      idx_q     <= '0;
      way_q     <= '0;
      val_clr_q <= 1'b0;
    end else begin
      val_clr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (miss_c) begin
            tag_q  <= pe_tag_d;
            vtag_q <= victim_tag_d;
            idx_q  <= pe_index_d;
            way_q  <= fill_or_victim_way_d;
            if (req_clean_d) begin
              state_q   <= ST_FILL_REQ;
              val_clr_q <= 1'b1;
            end else begin
              state_q <= ST_WB_REQ;
            end
          end
        end
        ST_WB_REQ: begin
          if (mem_bus.mem_gnt) state_q <= ST_WB_DATA;
        end
        ST_WB_DATA: begin
          if (mem_bus.mem_wready && beat_last) begin
            state_q   <= ST_FILL_REQ;
            val_clr_q <= 1'b1;
          end
        end
        ST_FILL_REQ: begin
          if (mem_bus.mem_gnt) state_q <= ST_FILL_DATA;
        end
        ST_FILL_DATA: begin
          if (mem_bus.mem_rvalid && beat_last) state_q <= ST_COMMIT;
        end
        ST_COMMIT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign pe_stall = busy_c || miss_c;

  assign mem_bus.mem_req    = (state_q == ST_WB_REQ) || (state_q == ST_FILL_REQ);
  assign mem_bus.mem_we     = (state_q == ST_WB_REQ);
  assign mem_bus.mem_addr   = (state_q == ST_WB_REQ)   ? {vtag_q, idx_q} :
                              (state_q == ST_FILL_REQ) ? {tag_q, idx_q}  : '0;
  assign mem_bus.mem_wvalid = in_wb_data_c;
  assign mem_bus.mem_wdata  = in_wb_data_c ? arr_rdata : '0;

  assign arr_way   = busy_c ? way_q : '0;
  assign arr_index = busy_c ? idx_q : '0;
  assign arr_beat  = (in_wb_data_c || in_fill_data_c) ? beat_cnt : '0;
  assign arr_we    = in_fill_data_c && mem_bus.mem_rvalid;
  assign arr_wdata = arr_we ? mem_bus.mem_rdata : '0;

  assign tag_we    = (state_q == ST_COMMIT);
  assign tag_wdata = tag_we ? tag_q : '0;
  assign val_set   = tag_we;
  assign mod_clr   = tag_we;
  assign fill_done = tag_we;
  assign val_clr   = val_clr_q;

endmodule
